uart_tx_arbiter: RTL

- Shares one UART transmitter between NUM_REQ event sources, e.g. push-buttons that have been debounced and passed through a positive-edge detector.
- Each source raises a one-cycle request pulse with a data byte; the block latches the byte as pending.
- Pending requests are granted round-robin, and each grant issues one tx_start to the transmitter.
- The next grant is withheld until the transmitter returns tx_done.

---
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among NUM_REQ sources
// Optional feature macro: UART_TX_ARB_OVERRUN_EN (sticky per-channel overrun flags, cleared by overrun_clr)
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_pulse,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      tx_done,
`ifdef UART_TX_ARB_OVERRUN_EN
    input  logic                      overrun_clr,
    output logic [NUM_REQ-1:0]        overrun,
`endif
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        pending,
    output logic                      busy
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   sel_q, sel_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [DATA_W-1:0]  data_q [NUM_REQ];
    logic [DATA_W-1:0]  data_d [NUM_REQ];
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, busy_d;

    logic               pick_vld;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   scan_idx;
    logic               granting;

    // Search upward from the channel after the last one served, wrapping at NUM_REQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!pick_vld && pending_q[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    assign granting = (state_q == S_IDLE) && pick_vld;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        grant_d    = grant_q;
        pending_d  = pending_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        data_d     = data_q;
        case (state_q)
            S_IDLE: begin
                if (granting) begin
                    sel_d                = pick_idx;
                    grant_d              = NUM_REQ'(1) << pick_idx;
                    tx_data_d            = data_q[pick_idx];
                    pending_d[pick_idx]  = 1'b0;
                    state_d              = S_START;
                end
            end
            S_START: begin
                tx_start_d = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done) begin
                    ptr_d   = sel_q;
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Capture runs after the grant so a same-cycle pulse re-arms the granted channel.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_pulse[i]) begin
                pending_d[i] = 1'b1;
                data_d[i]    = req_data[i*DATA_W +: DATA_W];
            end
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= PTR_W'(NUM_REQ - 1);
            sel_q      <= '0;
            grant_q    <= '0;
            pending_q  <= '0;
            data_q     <= '{default: '0};
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            grant_q    <= grant_d;
            pending_q  <= pending_d;
            data_q     <= data_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
        end
    end

`ifdef UART_TX_ARB_OVERRUN_EN
    logic [NUM_REQ-1:0] overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_clr ? '0 : overrun_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_pulse[i] && pending_q[i] && !(granting && pick_idx == PTR_W'(i))) begin
                overrun_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`endif

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign grant    = grant_q;
    assign pending  = pending_q;
    assign busy     = busy_q;

endmodule
